tetris_move_scheduler: RTL

Sequencing controller for the Tetris playfield datapath. It turns raw button activity and a gravity timer into a serialized stream of single playfield commands (clear, spawn, left, right, rotate, down, lock), issued over a valid/ready handshake. It waits for each command's done/ok result, and decides on locking, respawning and game over. It sits between the synchronized button and switch inputs and the playfield/collision datapath that feeds VGA rendering.

---
 rtl/tetris_move_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler
// Turns button edges and a gravity timer into a serialized stream of playfield
// commands over a valid/ready handshake, waits for each command's done/ok, and
// handles locking, respawn and game over.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 game-enable switch (level)
//   btn_left/right/rot/drop  synchronized button levels, active-high
//   cmd_valid, cmd_op     command offer (0 CLEAR,1 SPAWN,2 LEFT,3 RIGHT,4 ROT,5 DOWN,6 LOCK)
//   cmd_ready             datapath accepts the offered command
//   cmd_done, cmd_ok      one-cycle completion pulse and its legality result
//   playing, game_over    game status
//   pieces                number of completed LOCK commands (wraps)
module tetris_move_scheduler #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned TICK_W   = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rot,
  input  logic        btn_drop,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  input  logic        cmd_ready,
  input  logic        cmd_done,
  input  logic        cmd_ok,
  output logic        playing,
  output logic        game_over,
  output logic [15:0] pieces
);

  localparam logic [2:0] OpClear = 3'd0;
  localparam logic [2:0] OpSpawn = 3'd1;
  localparam logic [2:0] OpLeft  = 3'd2;
  localparam logic [2:0] OpRight = 3'd3;
  localparam logic [2:0] OpRot   = 3'd4;
  localparam logic [2:0] OpDown  = 3'd5;
  localparam logic [2:0] OpLock  = 3'd6;

  // Pending bit indices
  localparam int PDown  = 0;
  localparam int PRight = 1;
  localparam int PLeft  = 2;
  localparam int PRot   = 3;

  typedef enum logic [2:0] {
    StIdle, StClear, StSpawn, StReady, StIssue, StWait, StLock, StOver
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              valid_q, playing_q, over_q;
  logic [15:0]       pieces_q, pieces_d;
  logic [3:0]        prev_q;
  logic [3:0]        pend_q, pend_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

  logic [3:0] pend_clr;
  logic       pend_clr_all;
  logic       spawn_ok;
  logic       tick;
  logic [3:0] btns;
  logic [3:0] rise;

  assign btns = {btn_rot, btn_left, btn_right, btn_drop};
  assign rise = btns & ~prev_q;

  // Next-state decision. CLEAR/SPAWN/LOCK are single decision cycles that latch
  // their op and reuse ISSUE/WAIT; WAIT dispatches on the latched op.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    pend_clr     = 4'b0000;
    pend_clr_all = 1'b0;
    pieces_d     = pieces_q;
    spawn_ok     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        if (!start) begin
          state_d = StIdle;
        end else begin
          op_d         = OpClear;
          pend_clr_all = 1'b1;
          state_d      = StIssue;
        end
      end
      StSpawn: begin
        if (!start) begin
          state_d = StIdle;
        end else begin
          op_d    = OpSpawn;
          state_d = StIssue;
        end
      end
      StLock: begin
        if (!start) begin
          state_d = StIdle;
        end else begin
          op_d    = OpLock;
          state_d = StIssue;
        end
      end
      StReady: begin
        if (!start) begin
          state_d = StIdle;
        end else if (pend_q[PRot]) begin
          op_d = OpRot;   pend_clr[PRot]   = 1'b1; state_d = StIssue;
        end else if (pend_q[PLeft]) begin
          op_d = OpLeft;  pend_clr[PLeft]  = 1'b1; state_d = StIssue;
        end else if (pend_q[PRight]) begin
          op_d = OpRight; pend_clr[PRight] = 1'b1; state_d = StIssue;
        end else if (pend_q[PDown]) begin
          op_d = OpDown;  pend_clr[PDown]  = 1'b1; state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready) state_d = StWait;
      end
      StWait: begin
        if (cmd_done) begin
          case (op_q)
            OpClear: state_d = StSpawn;
            OpSpawn: begin
              spawn_ok = cmd_ok;
              state_d  = cmd_ok ? StReady : StOver;
            end
            OpLock: begin
              pieces_d     = pieces_q + 16'd1;
              pend_clr_all = 1'b1;
              state_d      = StSpawn;
            end
            OpDown:  state_d = cmd_ok ? StReady : StLock;
            default: state_d = StReady;
          endcase
          // Game disabled mid-command: stop after this completion.
          if (!start && state_d != StOver) state_d = StIdle;
        end
      end
      StOver: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Gravity: counts only in READY/ISSUE/WAIT; a successful spawn restarts it.
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (spawn_ok) begin
      tick_cnt_d = '0;
    end else if (state_q == StReady || state_q == StIssue || state_q == StWait) begin
      if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
        tick_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Set wins over clear; edges are only captured during play.
  always_comb begin
    pend_d = (pend_q & ~pend_clr & ~{4{pend_clr_all}})
           | (playing_q ? rise : 4'b0000)
           | {3'b000, tick};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpClear;
      valid_q    <= 1'b0;
      playing_q  <= 1'b0;
      over_q     <= 1'b0;
      pieces_q   <= 16'd0;
      prev_q     <= 4'b0000;
      pend_q     <= 4'b0000;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      valid_q    <= (state_d == StIssue);
      playing_q  <= !(state_d == StIdle || state_d == StOver);
      over_q     <= (state_d == StOver);
      pieces_q   <= pieces_d;
      prev_q     <= btns;
      pend_q     <= pend_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_op    = op_q;
  assign playing   = playing_q;
  assign game_over = over_q;
  assign pieces    = pieces_q;

endmodule
